// File: rtl/bru_q.sv
// Branch resolution unit with an in-order result queue and epoch-based squashing.
// Optional perf counters are enabled by defining BRU_Q_PERF_CNT_EN.
package bru_q_pkg;
  localparam int EPOCH_W = 2;
  localparam int ROB_W   = 5;
  localparam int PHYS_W  = 6;

  typedef enum logic [1:0] {
    UOP_ALU,
    UOP_BRANCH,
    UOP_JUMP,
    UOP_OTHER
  } uop_class_e;

  typedef enum logic [2:0] {
    BR_BEQ,
    BR_BNE,
    BR_BLT,
    BR_BGE,
    BR_BLTU,
    BR_BGEU
  } branch_type_e;

  typedef struct packed {
    uop_class_e          uop_class;
    branch_type_e        branch_type;
    logic                uses_rs1;
    logic                uses_rd;
    logic [31:0]         pc;
    logic [31:0]         imm;
    logic                pred_taken;
    logic [31:0]         pred_target;
    logic [EPOCH_W-1:0]  epoch;
    logic [ROB_W-1:0]    rob_idx;
    logic [PHYS_W-1:0]   prd_new;
  } rs_uop_t;
endpackage

module bru_q
  import bru_q_pkg::*;
#(
  parameter int DEPTH  = 4,
  parameter int PERF_W = 32
) (
  input  logic                       clk,
  input  logic                       rst_n,
  input  logic                       flush,
  input  logic [EPOCH_W-1:0]         cur_epoch,
  input  logic                       req_valid,
  output logic                       req_ready,
  input  rs_uop_t                    req_uop,
  input  logic [31:0]                rs1_val,
  input  logic [31:0]                rs2_val,
  output logic                       wb_valid,
  input  logic                       wb_ready,
  output logic                       wb_uses_rd,
  output logic [EPOCH_W-1:0]         wb_epoch,
  output logic [ROB_W-1:0]           wb_rob_idx,
  output logic [PHYS_W-1:0]          wb_prd_new,
  output logic [31:0]                wb_data,
  output logic [31:0]                wb_pc,
  output logic                       mispredict,
  output logic                       redirect_valid,
  output logic [31:0]                redirect_pc,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic [PERF_W-1:0]          perf_br_cnt,
  output logic [PERF_W-1:0]          perf_mp_cnt
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = $clog2(DEPTH+1);

  typedef struct packed {
    logic               uses_rd;
    logic [EPOCH_W-1:0] epoch;
    logic [ROB_W-1:0]   rob_idx;
    logic [PHYS_W-1:0]  prd_new;
    logic [31:0]        data;
    logic [31:0]        pc;
    logic [31:0]        redirect_pc;
    logic               mispredict;
  } entry_t;

  entry_t           mem [DEPTH];
  entry_t           new_entry;
  entry_t           head;
  logic [PTR_W-1:0] wr_ptr, rd_ptr;

  logic        cond, taken;
  logic [31:0] pc_plus4, br_target, jalr_target, target;
  logic        head_stale, deq, pop, push;

  // Branch condition and target resolution for the incoming uop.
  always_comb begin
    // NOTE: every always_comb output gets a default first so no path leaves a latch.
    cond        = 1'b0;
    taken       = 1'b0;
    pc_plus4    = req_uop.pc + 32'd4;
    br_target   = req_uop.pc + req_uop.imm;
    jalr_target = (rs1_val + req_uop.imm) & ~32'd1;
    target      = pc_plus4;

    case (req_uop.branch_type)
      BR_BEQ:  cond = (rs1_val == rs2_val);
      BR_BNE:  cond = (rs1_val != rs2_val);
      BR_BLT:  cond = ($signed(rs1_val) <  $signed(rs2_val));
      BR_BGE:  cond = ($signed(rs1_val) >= $signed(rs2_val));
      BR_BLTU: cond = (rs1_val <  rs2_val);
      BR_BGEU: cond = (rs1_val >= rs2_val);
      default: cond = 1'b0;
    endcase

    case (req_uop.uop_class)
      UOP_BRANCH: begin
        taken  = cond;
        target = br_target;
      end
      UOP_JUMP: begin
        taken  = 1'b1;
        target = req_uop.uses_rs1 ? jalr_target : br_target;
      end
      default: begin
        taken  = 1'b0;
        target = pc_plus4;
      end
    endcase

    new_entry.uses_rd     = req_uop.uses_rd;
    new_entry.epoch       = req_uop.epoch;
    new_entry.rob_idx     = req_uop.rob_idx;
    new_entry.prd_new     = req_uop.prd_new;
    new_entry.data        = pc_plus4;
    new_entry.pc          = req_uop.pc;
    new_entry.redirect_pc = taken ? target : pc_plus4;
    new_entry.mispredict  = (taken != req_uop.pred_taken) ||
                            (taken && (target != req_uop.pred_target));
  end

  // Queue control: a stale head drains itself without waiting on the consumer.
  assign head       = mem[rd_ptr];
  assign head_stale = (count != '0) && (head.epoch != cur_epoch);
  assign wb_valid   = (count != '0) && !head_stale && !flush;
  assign deq        = wb_valid && wb_ready;
  assign pop        = deq || (head_stale && !flush);
  assign req_ready  = !flush && ((count < CNT_W'(DEPTH)) || pop);
  assign push       = req_valid && req_ready && (req_uop.epoch == cur_epoch);

  assign wb_uses_rd     = head.uses_rd;
  assign wb_epoch       = head.epoch;
  assign wb_rob_idx     = head.rob_idx;
  assign wb_prd_new     = head.prd_new;
  assign wb_data        = head.data;
  assign wb_pc          = head.pc;
  assign redirect_pc    = head.redirect_pc;
  assign mispredict     = wb_valid && head.mispredict;
  assign redirect_valid = deq && head.mispredict;

  // NOTE: the payload array carries no reset; validity lives entirely in count/pointers.
  always_ff @(posedge clk) begin
    if (push) mem[wr_ptr] <= new_entry;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      count <= count + CNT_W'(push) - CNT_W'(pop);
    end
  end

`ifdef BRU_Q_PERF_CNT_EN
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      perf_br_cnt <= '0;
      perf_mp_cnt <= '0;
    end else begin
      if (deq)            perf_br_cnt <= perf_br_cnt + PERF_W'(1);
      if (redirect_valid) perf_mp_cnt <= perf_mp_cnt + PERF_W'(1);
    end
  end
`else
  assign perf_br_cnt = '0;
  assign perf_mp_cnt = '0;
`endif

endmodule

// File: tb/tb_bru_q.sv
// Self-checking bench for bru_q: vector table through a scoreboard, plus
// directed sequences for full queue, stale epoch, flush and mid-run reset.
module tb_bru_q;
  import bru_q_pkg::*;

  localparam int DEPTH  = 4;
  localparam int PERF_W = 32;
  localparam int CNT_W  = $clog2(DEPTH+1);

  logic               clk, rst_n, flush;
  logic [EPOCH_W-1:0] cur_epoch;
  logic               req_valid, req_ready;
  rs_uop_t            req_uop;
  logic [31:0]        rs1_val, rs2_val;
  logic               wb_valid, wb_ready, wb_uses_rd;
  logic [EPOCH_W-1:0] wb_epoch;
  logic [ROB_W-1:0]   wb_rob_idx;
  logic [PHYS_W-1:0]  wb_prd_new;
  logic [31:0]        wb_data, wb_pc, redirect_pc;
  logic               mispredict, redirect_valid;
  logic [CNT_W-1:0]   count;
  logic [PERF_W-1:0]  perf_br_cnt, perf_mp_cnt;

  bru_q #(.DEPTH(DEPTH), .PERF_W(PERF_W)) dut (
    .clk(clk), .rst_n(rst_n), .flush(flush), .cur_epoch(cur_epoch),
    .req_valid(req_valid), .req_ready(req_ready), .req_uop(req_uop),
    .rs1_val(rs1_val), .rs2_val(rs2_val),
    .wb_valid(wb_valid), .wb_ready(wb_ready), .wb_uses_rd(wb_uses_rd),
    .wb_epoch(wb_epoch), .wb_rob_idx(wb_rob_idx), .wb_prd_new(wb_prd_new),
    .wb_data(wb_data), .wb_pc(wb_pc), .mispredict(mispredict),
    .redirect_valid(redirect_valid), .redirect_pc(redirect_pc),
    .count(count), .perf_br_cnt(perf_br_cnt), .perf_mp_cnt(perf_mp_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks   = 0;
  int failures = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  typedef struct {
    uop_class_e   cls;
    branch_type_e bt;
    logic         u1;
    logic [31:0]  pc, imm, rs1, rs2;
    logic         pt;
    logic [31:0]  ptgt;
    logic         mp;
    logic [31:0]  rpc;
  } vec_t;

  typedef struct {
    logic [31:0]       pc, data, rpc;
    logic              mp;
    logic [ROB_W-1:0]  rob;
    logic              uses_rd;
    logic [PHYS_W-1:0] prd;
  } exp_t;

  localparam int NVEC = 12;
  vec_t vecs [NVEC];
  exp_t sb [$];
  exp_t cur_exp;
  bit   sb_on  = 1'b0;
  int   sb_deq = 0;
  int   sb_mp  = 0;

  function automatic vec_t mk(input uop_class_e cls, input branch_type_e bt, input logic u1,
                              input logic [31:0] pc, input logic [31:0] imm,
                              input logic [31:0] rs1, input logic [31:0] rs2,
                              input logic pt, input logic [31:0] ptgt,
                              input logic mp, input logic [31:0] rpc);
    vec_t v;
    v.cls = cls; v.bt = bt; v.u1 = u1; v.pc = pc; v.imm = imm; v.rs1 = rs1; v.rs2 = rs2;
    v.pt = pt; v.ptgt = ptgt; v.mp = mp; v.rpc = rpc;
    return v;
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic drive_uop(input vec_t v, input logic [ROB_W-1:0] rob, input logic [EPOCH_W-1:0] ep);
    req_uop.uop_class   = v.cls;
    req_uop.branch_type = v.bt;
    req_uop.uses_rs1    = v.u1;
    req_uop.uses_rd     = rob[0];
    req_uop.pc          = v.pc;
    req_uop.imm         = v.imm;
    req_uop.pred_taken  = v.pt;
    req_uop.pred_target = v.ptgt;
    req_uop.epoch       = ep;
    req_uop.rob_idx     = rob;
    req_uop.prd_new     = PHYS_W'(rob) + PHYS_W'(1);
    rs1_val             = v.rs1;
    rs2_val             = v.rs2;
    cur_exp.pc          = v.pc;
    cur_exp.data        = v.pc + 32'd4;
    cur_exp.rpc         = v.rpc;
    cur_exp.mp          = v.mp;
    cur_exp.rob         = rob;
    cur_exp.uses_rd     = rob[0];
    cur_exp.prd         = PHYS_W'(rob) + PHYS_W'(1);
    req_valid           = 1'b1;
  endtask

  // Scoreboard monitor: pops on every DUT dequeue, pushes on every accepted in-epoch request.
  always @(negedge clk) begin
    if (rst_n) begin
      check("redirect_without_deq", 32'(redirect_valid && !(wb_valid && wb_ready)), 32'd0);
      if (wb_valid && wb_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_wb", 32'(wb_valid), 32'd0);
        end else begin
          exp_t e;
          e = sb.pop_front();
          check("wb_pc",          wb_pc,                e.pc);
          check("wb_data",        wb_data,              e.data);
          check("wb_rob_idx",     32'(wb_rob_idx),      32'(e.rob));
          check("wb_uses_rd",     32'(wb_uses_rd),      32'(e.uses_rd));
          check("wb_prd_new",     32'(wb_prd_new),      32'(e.prd));
          check("wb_epoch",       32'(wb_epoch),        32'(cur_epoch));
          check("mispredict",     32'(mispredict),      32'(e.mp));
          check("redirect_valid", 32'(redirect_valid),  32'(e.mp));
          check("redirect_pc",    redirect_pc,          e.rpc);
          sb_deq++;
          if (e.mp) sb_mp++;
        end
      end
      if (sb_on && req_valid && req_ready && !flush && (req_uop.epoch == cur_epoch))
        sb.push_back(cur_exp);
    end
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation exceeded time budget");
    $fatal(1, "timeout");
  end

  initial begin
    rst_n = 1'b0; flush = 1'b0; cur_epoch = '0; req_valid = 1'b0; req_uop = '0;
    rs1_val = '0; rs2_val = '0; wb_ready = 1'b0;
    cur_exp = '{default: '0};

    //                cls         bt       u1  pc            imm           rs1           rs2           pt  ptgt          mp  rpc
    vecs[0]  = mk(UOP_BRANCH, BR_BEQ,  0, 32'h100,      32'h20,       32'd5,        32'd5,        0, 32'h0,        1, 32'h120);
    vecs[1]  = mk(UOP_BRANCH, BR_BNE,  0, 32'h200,      32'h10,       32'd5,        32'd5,        0, 32'h0,        0, 32'h204);
    vecs[2]  = mk(UOP_BRANCH, BR_BLT,  0, 32'h300,      32'hFFFFFFF8, 32'hFFFFFFFF, 32'd1,        1, 32'h2F8,      0, 32'h2F8);
    vecs[3]  = mk(UOP_BRANCH, BR_BLTU, 0, 32'h400,      32'h40,       32'hFFFFFFFF, 32'd1,        1, 32'h440,      1, 32'h404);
    vecs[4]  = mk(UOP_BRANCH, BR_BGE,  0, 32'h500,      32'h100,      32'd3,        32'd3,        1, 32'h600,      0, 32'h600);
    vecs[5]  = mk(UOP_BRANCH, BR_BGEU, 0, 32'h600,      32'h8,        32'd1,        32'd2,        0, 32'h0,        0, 32'h604);
    vecs[6]  = mk(UOP_BRANCH, BR_BGE,  0, 32'h700,      32'h20,       32'h80000000, 32'd0,        1, 32'h720,      1, 32'h704);
    vecs[7]  = mk(UOP_JUMP,   BR_BEQ,  1, 32'h800,      32'h4,        32'h1003,     32'd0,        1, 32'h1006,     0, 32'h1006);
    vecs[8]  = mk(UOP_JUMP,   BR_BEQ,  0, 32'h900,      32'h100,      32'd0,        32'd0,        1, 32'h1000,     1, 32'hA00);
    vecs[9]  = mk(UOP_ALU,    BR_BEQ,  0, 32'hA00,      32'h0,        32'd7,        32'd7,        0, 32'h0,        0, 32'hA04);
    vecs[10] = mk(UOP_ALU,    BR_BEQ,  0, 32'hB00,      32'h0,        32'd0,        32'd0,        1, 32'hB04,      1, 32'hB04);
    vecs[11] = mk(UOP_JUMP,   BR_BEQ,  0, 32'hFFFFFFF0, 32'h20,       32'd0,        32'd0,        1, 32'h10,       0, 32'h10);

    // Reset state.
    #1;
    check("rst_count",          32'(count),          32'd0);
    check("rst_wb_valid",       32'(wb_valid),       32'd0);
    check("rst_redirect_valid", 32'(redirect_valid), 32'd0);
    check("rst_mispredict",     32'(mispredict),     32'd0);
    check("rst_req_ready",      32'(req_ready),      32'd1);
    check("rst_perf_br",        perf_br_cnt,         32'd0);
    check("rst_perf_mp",        perf_mp_cnt,         32'd0);
    #20;
    @(negedge clk) rst_n = 1'b1;

    // Stale-epoch drain: three queued entries become stale and pop one per cycle.
    sb_on = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      drive_uop(vecs[i*3], ROB_W'(i), 2'd0);
    end
    step();
    req_valid = 1'b0;
    check("stale_fill_count", 32'(count), 32'd3);
    check("stale_fill_valid", 32'(wb_valid), 32'd1);
    cur_epoch = 2'd1;
    for (int k = 0; k < 3; k++) begin
      #1;
      check("stale_wb_valid", 32'(wb_valid),       32'd0);
      check("stale_redirect", 32'(redirect_valid), 32'd0);
      step();
      check("stale_count", 32'(count), 32'(2 - k));
    end
    // Old-epoch request is accepted but dropped.
    drive_uop(vecs[1], 5'd7, 2'd0);
    #1;
    check("discard_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("discard_count", 32'(count), 32'd0);

    // Flush with a pending request on a three-entry queue.
    for (int i = 0; i < 3; i++) begin
      step();
      drive_uop(vecs[i], ROB_W'(i), 2'd1);
    end
    step();
    req_valid = 1'b0;
    check("flush_pre_count", 32'(count), 32'd3);
    drive_uop(vecs[4], 5'd9, 2'd1);
    flush = 1'b1;
    #1;
    check("flush_req_ready", 32'(req_ready), 32'd0);
    check("flush_wb_valid",  32'(wb_valid),  32'd0);
    step();
    flush = 1'b0;
    req_valid = 1'b0;
    #1;
    check("flush_count",      32'(count),    32'd0);
    check("flush_post_valid", 32'(wb_valid), 32'd0);

    // Reset mid-operation with mispredicting entries queued.
    step();
    drive_uop(vecs[0], 5'd1, 2'd1);
    step();
    drive_uop(vecs[3], 5'd2, 2'd1);
    step();
    req_valid = 1'b0;
    check("midrst_pre_count", 32'(count), 32'd2);
    #1;
    rst_n = 1'b0;
    #1;
    check("midrst_count",     32'(count),     32'd0);
    check("midrst_wb_valid",  32'(wb_valid),  32'd0);
    check("midrst_req_ready", 32'(req_ready), 32'd1);
    check("midrst_perf_br",   perf_br_cnt,    32'd0);
    @(negedge clk) rst_n = 1'b1;
    wb_ready = 1'b1;
    for (int k = 0; k < 3; k++) begin
      step();
      check("midrst_post_valid", 32'(wb_valid), 32'd0);
    end

    // Vector table through the scoreboard, one request per cycle with wb_ready high.
    sb_on = 1'b1;
    for (int i = 0; i < NVEC; i++) begin
      step();
      if (i > 0) check("wb_valid_next_cycle", 32'(wb_valid), 32'd1);
      drive_uop(vecs[i], ROB_W'(i), 2'd1);
    end
    step();
    check("wb_valid_last", 32'(wb_valid), 32'd1);
    req_valid = 1'b0;
    step();
    step();
    check("table_drain", 32'(sb.size()), 32'd0);

    // Full queue: five requests with wb_ready low, then enqueue and dequeue together.
    wb_ready = 1'b0;
    for (int i = 0; i < 4; i++) begin
      step();
      drive_uop(vecs[9], ROB_W'(16 + i), 2'd1);
    end
    step();
    drive_uop(vecs[9], 5'd20, 2'd1);
    #1;
    check("full_count",     32'(count),     32'd4);
    check("full_req_ready", 32'(req_ready), 32'd0);
    step();
    check("full_hold_count", 32'(count), 32'd4);
    wb_ready = 1'b1;
    #1;
    check("full_deq_req_ready", 32'(req_ready), 32'd1);
    step();
    req_valid = 1'b0;
    check("full_deq_count", 32'(count), 32'd4);
    for (int k = 0; k < 4; k++) step();
    check("full_drain_count", 32'(count), 32'd0);
    step();
    check("full_drain_sb", 32'(sb.size()), 32'd0);

    // Perf counters since the last reset.
`ifdef BRU_Q_PERF_CNT_EN
    check("perf_br_cnt", perf_br_cnt, 32'(sb_deq));
    check("perf_mp_cnt", perf_mp_cnt, 32'(sb_mp));
    check("perf_br_total", 32'(sb_deq), 32'd17);
`else
    check("perf_br_cnt", perf_br_cnt, 32'd0);
    check("perf_mp_cnt", perf_mp_cnt, 32'd0);
    check("perf_br_total", 32'(sb_deq), 32'd17);
`endif
    check("perf_mp_total", 32'(sb_mp), 32'd5);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
